python_timing_gen: RTL and testbench
====================================

# python_timing_gen

Free-running or triggered frame-timing and test-pattern generator for the Python sensor simulation model. It produces `fval`, `lval` and the multi-channel parallel pixel bus that feed the sensor model's map → format → ctrl-insert → serializer chain. It runs on the parallel clock. Frame geometry comes from run-time inputs, so a bench can sweep resolutions without recompiling.

## Interface
- `DATA_WIDTH`, 10, bits per pixel.
- `CHANNEL_NUM`, 4, pixels per clock (one per channel).
- `CFG_WIDTH`, 16, width of every geometry input.

Ports:
- `clk` in 1: parallel pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `i_init_done` in 1: sensor registers loaded; frames start only while high.
- `i_trigger_mode` in 1: 0 = free-run, 1 = one frame per trigger.
- `i_trigger` in 1: single-cycle trigger pulse.
- `iv_line_clks` in CFG_WIDTH: active clocks per line (pixels/CHANNEL_NUM).
- `iv_line_num` in CFG_WIDTH: active lines per frame.
- `iv_hblank` in CFG_WIDTH: lval-low clocks between lines.
- `iv_front` in CFG_WIDTH: fval-high, lval-low clocks before the first line.
- `iv_back` in CFG_WIDTH: fval-high, lval-low clocks after the last line.
- `iv_vblank` in CFG_WIDTH: fval-low clocks after each frame.
- `o_fval` out 1: frame valid.
- `o_lval` out 1: line valid.
- `ov_pix_data` out DATA_WIDTH*CHANNEL_NUM: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_frame_done` out 1: one-cycle pulse on the last vblank clock.
- `ov_frame_cnt` out 16: completed-frame counter; wraps at 2^16.

## Operation
- FSM states and outputs:
  - `S_IDLE`: fval=0, lval=0.
  - `S_FRONT`: fval=1, lval=0.
  - `S_LINE`: fval=1, lval=1.
  - `S_HBLANK`: fval=1, lval=0.
  - `S_BACK`: fval=1, lval=0.
  - `S_VBLANK`: fval=0, lval=0.
- Transitions:
  - `S_IDLE` → `S_FRONT` when `i_init_done` is high and the frame is enabled. Enabled means `i_trigger_mode`=0, or `i_trigger`=1 in that cycle.
  - `S_FRONT` → `S_LINE` after `front` clocks.
  - `S_LINE` → `S_HBLANK` after `line_clks` clocks, unless this was the last line; the last line goes to `S_BACK`.
  - `S_HBLANK` → `S_LINE` after `hblank` clocks.
  - `S_BACK` → `S_VBLANK` after `back` clocks.
  - `S_VBLANK` after `vblank` clocks: → `S_FRONT` if free-run and `i_init_done` is high, else → `S_IDLE`.
- Geometry inputs are latched into shadow registers on every entry to `S_FRONT`. Changes mid-frame take effect at the next frame.
- Zero handling:
  - Blank counts (`front`, `hblank`, `back`, `vblank`) of 0 are treated as 1.
  - If `iv_line_clks`=0 or `iv_line_num`=0 at the start decision, the FSM stays in `S_IDLE`.
- Triggers are accepted only in `S_IDLE`. Triggers arriving in any other state are dropped, not queued.
- If `i_init_done` falls mid-frame, the current frame completes, then the FSM returns to `S_IDLE`.
- Counters: `clk_cnt` (per-state, CFG_WIDTH), `line_cnt` (CFG_WIDTH), `pix_cnt` (clocks within the line).
- `ov_frame_cnt` increments on `o_frame_done`.
- `ov_pix_data` is 0 whenever lval=0.

## Timing
- All outputs are registered.
- Reset: every output is 0, FSM = `S_IDLE`, all counters 0. This holds on the cycle after `reset` is sampled high, including mid-frame.
- Trigger latency: `i_trigger` sampled high in `S_IDLE` at edge N → `o_fval`=1 after edge N+1.
- Free-run period = front + line_num*line_clks + (line_num−1)*hblank + back + vblank clocks.
- `o_lval` rises at least 1 clock after `o_fval` rises and falls at least 1 clock before `o_fval` falls.
- Data is aligned to `o_lval` (same cycle).

## Configuration
- `PYTHON_TG_RAMP_EN`:
  - Defined: channel k pixel = (ov_frame_cnt + line_cnt + pix_cnt*CHANNEL_NUM + k) mod 2^DATA_WIDTH.
  - Undefined: every active pixel = all-ones DATA_WIDTH'h3FF pattern for the given width, i.e. {DATA_WIDTH{1'b1}}.
  - Timing is identical in both builds.

## Structure
- Shared package `python_pkg`: FSM state enum, `CFG_WIDTH` default, pixel-slice helper function.
- Sub-module `python_tg_pattern`: combinational data generator from counters. The only place the macro is tested.

## Test plan
Defaults for all cases unless stated: DW=10, CH=4, line_clks=4, line_num=2, hblank=3, front=2, back=2, vblank=5.
- Free-run with defaults, ramp build → period 20 clocks; fval high 15; lval high 4+4.
  - Line 0 data: {3,2,1,0}, {7,6,5,4}, …, {15,14,13,12}.
  - Line 1 first clock: {4,3,2,1}.
- Trigger mode, pulse at cycle 10 → fval rises at cycle 11; exactly one frame; `ov_frame_cnt`=1. A second pulse during vblank is ignored; no second frame.
- Reset asserted on the 3rd lval clock of line 1 → next cycle all outputs 0, frame_cnt 0. After release, the first frame restarts from `S_FRONT` with ramp offset 0.
- `iv_line_clks` changed from 4 to 6 mid-frame → current frame keeps 4-clock lines; next frame has 6.
- `iv_hblank`=0, `iv_front`=0 → one-clock gaps. `iv_line_num`=0 → fval stays low indefinitely.
- Non-ramp build → every active pixel = 10'h3FF, zero outside lval; timing matches the ramp build.

Source files
------------

// File: rtl/python_pkg.sv
// Shared types and helpers for the Python sensor timing/pattern generator.
package python_pkg;

  localparam int CFG_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRONT,
    S_LINE,
    S_HBLANK,
    S_BACK,
    S_VBLANK
  } tg_state_t;

  // Ramp value for one channel slice; the caller truncates to its pixel width.
  function automatic logic [31:0] pix_slice_value(
    input logic [31:0] frame_cnt,
    input logic [31:0] line_cnt,
    input logic [31:0] pix_cnt,
    input int unsigned chan_num,
    input int unsigned chan_idx
  );
    return frame_cnt + line_cnt + pix_cnt * chan_num + chan_idx;
  endfunction

endpackage

// File: rtl/python_tg_pattern.sv
// Combinational pixel generator driven by the frame/line/pixel counters.
// PYTHON_TG_RAMP_EN selects a moving ramp; otherwise active pixels are all-ones.
module python_tg_pattern
  import python_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 4,
  parameter int CFG_WIDTH   = CFG_WIDTH_DEFAULT
) (
  input  logic                              active,
  input  logic [15:0]                       frame_cnt,
  input  logic [CFG_WIDTH-1:0]              line_cnt,
  input  logic [CFG_WIDTH-1:0]              pix_cnt,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_data
);

`ifdef PYTHON_TG_RAMP_EN
  always_comb begin
    pix_data = '0;
    if (active) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        pix_data[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(pix_slice_value(
          32'(frame_cnt), 32'(line_cnt), 32'(pix_cnt),
          unsigned'(CHANNEL_NUM), unsigned'(k)));
      end
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{frame_cnt, line_cnt, pix_cnt};

  always_comb begin
    pix_data = '0;
    if (active) begin
      pix_data = {(DATA_WIDTH*CHANNEL_NUM){1'b1}};
    end
  end
`endif

endmodule

// File: rtl/python_timing_gen.sv
// Frame timing (fval/lval) and test-pattern generator for the Python sensor model.
// Pixel content depends on PYTHON_TG_RAMP_EN (see python_tg_pattern); timing does not.
module python_timing_gen
  import python_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 4,
  parameter int CFG_WIDTH   = CFG_WIDTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_init_done,
  input  logic                              i_trigger_mode,
  input  logic                              i_trigger,
  input  logic [CFG_WIDTH-1:0]              iv_line_clks,
  input  logic [CFG_WIDTH-1:0]              iv_line_num,
  input  logic [CFG_WIDTH-1:0]              iv_hblank,
  input  logic [CFG_WIDTH-1:0]              iv_front,
  input  logic [CFG_WIDTH-1:0]              iv_back,
  input  logic [CFG_WIDTH-1:0]              iv_vblank,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done,
  output logic [15:0]                       ov_frame_cnt
);

  localparam logic [CFG_WIDTH-1:0] CNT_ONE = CFG_WIDTH'(1);

  tg_state_t state;

  logic [CFG_WIDTH-1:0] clk_cnt;
  logic [CFG_WIDTH-1:0] line_cnt;
  logic [CFG_WIDTH-1:0] pix_cnt;

  // Shadow geometry holds the last index of each phase (length minus one).
  logic [CFG_WIDTH-1:0] line_clks_last;
  logic [CFG_WIDTH-1:0] line_num_last;
  logic [CFG_WIDTH-1:0] hblank_last;
  logic [CFG_WIDTH-1:0] front_last;
  logic [CFG_WIDTH-1:0] back_last;
  logic [CFG_WIDTH-1:0] vblank_last;

  logic start_ok;
  logic vblank_end;
  logic start_frame;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] pattern_data;

  // A blank length of zero behaves as a single clock.
  function automatic logic [CFG_WIDTH-1:0] blank_last(input logic [CFG_WIDTH-1:0] n);
    return (n == '0) ? '0 : n - CNT_ONE;
  endfunction

  assign start_ok   = i_init_done && (iv_line_clks != '0) && (iv_line_num != '0);
  assign vblank_end = (state == S_VBLANK) && (clk_cnt == vblank_last);
  assign start_frame = ((state == S_IDLE) && start_ok && (!i_trigger_mode || i_trigger)) ||
                       (vblank_end && start_ok && !i_trigger_mode);

  python_tg_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNEL_NUM(CHANNEL_NUM),
    .CFG_WIDTH  (CFG_WIDTH)
  ) u_pattern (
    .active   (state == S_LINE),
    .frame_cnt(ov_frame_cnt),
    .line_cnt (line_cnt),
    .pix_cnt  (pix_cnt),
    .pix_data (pattern_data)
  );

  // Outputs are a one-stage registered decode of the state, so data stays aligned to lval.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      clk_cnt        <= '0;
      line_cnt       <= '0;
      pix_cnt        <= '0;
      line_clks_last <= '0;
      line_num_last  <= '0;
      hblank_last    <= '0;
      front_last     <= '0;
      back_last      <= '0;
      vblank_last    <= '0;
      o_fval         <= 1'b0;
      o_lval         <= 1'b0;
      ov_pix_data    <= '0;
      o_frame_done   <= 1'b0;
      ov_frame_cnt   <= '0;
    end else begin
      o_fval       <= (state != S_IDLE) && (state != S_VBLANK);
      o_lval       <= (state == S_LINE);
      ov_pix_data  <= pattern_data;
      o_frame_done <= vblank_end;
      if (o_frame_done) begin
        ov_frame_cnt <= ov_frame_cnt + 16'd1;
      end

      if (start_frame) begin
        line_clks_last <= iv_line_clks - CNT_ONE;
        line_num_last  <= iv_line_num - CNT_ONE;
        hblank_last    <= blank_last(iv_hblank);
        front_last     <= blank_last(iv_front);
        back_last      <= blank_last(iv_back);
        vblank_last    <= blank_last(iv_vblank);
      end

      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          if (start_frame) begin
            state <= S_FRONT;
          end
        end
        S_FRONT: begin
          if (clk_cnt == front_last) begin
            clk_cnt  <= '0;
            line_cnt <= '0;
            pix_cnt  <= '0;
            state    <= S_LINE;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        S_LINE: begin
          if (pix_cnt == line_clks_last) begin
            pix_cnt <= '0;
            state   <= (line_cnt == line_num_last) ? S_BACK : S_HBLANK;
          end else begin
            pix_cnt <= pix_cnt + CNT_ONE;
          end
        end
        S_HBLANK: begin
          if (clk_cnt == hblank_last) begin
            clk_cnt  <= '0;
            line_cnt <= line_cnt + CNT_ONE;
            state    <= S_LINE;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        S_BACK: begin
          if (clk_cnt == back_last) begin
            clk_cnt <= '0;
            state   <= S_VBLANK;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        S_VBLANK: begin
          if (vblank_end) begin
            clk_cnt <= '0;
            state   <= start_frame ? S_FRONT : S_IDLE;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_python_timing_gen.sv
// Self-checking bench: compares every output cycle against a frame-level model
// that expands geometry into an expected fval/lval/data/done/count stream.
`timescale 1ns/1ps
module tb_python_timing_gen;

  localparam int DW = 10;
  localparam int CH = 4;
  localparam int CW = 16;
`ifdef PYTHON_TG_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic i_init_done;
  logic i_trigger_mode;
  logic i_trigger;
  logic [CW-1:0] iv_line_clks, iv_line_num, iv_hblank, iv_front, iv_back, iv_vblank;
  logic o_fval, o_lval, o_frame_done;
  logic [DW*CH-1:0] ov_pix_data;
  logic [15:0] ov_frame_cnt;

  always #5 clk = ~clk;

  python_timing_gen #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CFG_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .i_init_done(i_init_done),
    .i_trigger_mode(i_trigger_mode), .i_trigger(i_trigger),
    .iv_line_clks(iv_line_clks), .iv_line_num(iv_line_num), .iv_hblank(iv_hblank),
    .iv_front(iv_front), .iv_back(iv_back), .iv_vblank(iv_vblank),
    .o_fval(o_fval), .o_lval(o_lval), .ov_pix_data(ov_pix_data),
    .o_frame_done(o_frame_done), .ov_frame_cnt(ov_frame_cnt)
  );

  typedef struct packed {
    logic           fval;
    logic           lval;
    logic           done;
    logic [15:0]    fcnt;
    logic [DW*CH-1:0] data;
  } obs_t;

  obs_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   model_fcnt = 0;

  function automatic logic [DW*CH-1:0] model_pixels(int frame, int line, int pix);
    logic [DW*CH-1:0] v;
    for (int k = 0; k < CH; k++)
      v[k*DW +: DW] = RAMP ? DW'((frame + line + pix*CH + k) % (1 << DW)) : {DW{1'b1}};
    return v;
  endfunction

  function automatic void push(logic f, logic l, logic d, logic [DW*CH-1:0] data);
    obs_t e;
    e.fval = f; e.lval = l; e.done = d; e.fcnt = 16'(model_fcnt); e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void push_idle(int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, '0);
  endfunction

  // One whole frame, blank lengths of zero counting as one clock.
  function automatic void add_frame(int lc, int ln, int hb, int fr, int bk, int vb);
    int hb1, fr1, bk1, vb1;
    hb1 = (hb == 0) ? 1 : hb;
    fr1 = (fr == 0) ? 1 : fr;
    bk1 = (bk == 0) ? 1 : bk;
    vb1 = (vb == 0) ? 1 : vb;
    for (int i = 0; i < fr1; i++) push(1'b1, 1'b0, 1'b0, '0);
    for (int l = 0; l < ln; l++) begin
      for (int p = 0; p < lc; p++) push(1'b1, 1'b1, 1'b0, model_pixels(model_fcnt, l, p));
      if (l != ln - 1)
        for (int i = 0; i < hb1; i++) push(1'b1, 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < bk1; i++) push(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < vb1; i++) push(1'b0, 1'b0, (i == vb1 - 1), '0);
    model_fcnt = (model_fcnt + 1) % 65536;
  endfunction

  function automatic obs_t sample();
    return {o_fval, o_lval, o_frame_done, ov_frame_cnt, ov_pix_data};
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("fval=%b lval=%b done=%b cnt=%0d data=%h", v.fval, v.lval, v.done, v.fcnt, v.data);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_geom(int lc, int ln, int hb, int fr, int bk, int vb);
    iv_line_clks = CW'(lc); iv_line_num = CW'(ln); iv_hblank = CW'(hb);
    iv_front = CW'(fr); iv_back = CW'(bk); iv_vblank = CW'(vb);
  endtask

  task automatic do_reset();
    reset = 1'b1; i_init_done = 1'b0; i_trigger = 1'b0; i_trigger_mode = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete();
    model_fcnt = 0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; i_init_done = 1'b1; i_trigger = 1'b0; i_trigger_mode = 1'b0;
    set_geom(4, 2, 3, 2, 2, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = sample();
      n_assert++;
      if (o !== obs_t'(0)) begin
        n_fail++;
        $display("[TB] FAIL reset cycle %0d: got %s, expected all zero", i, fmt(o));
      end
    end
    reset = 1'b0;
    i_init_done = 1'b0;
  endtask

  task automatic test_free_run();
    obs_t o, e;
    int n;
    do_reset();
    set_geom(4, 2, 3, 2, 2, 5);
    i_init_done = 1'b1;
    push_idle(1);
    for (int f = 0; f < 3; f++) add_frame(4, 2, 3, 2, 2, 5);
    push_idle(10);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL free_run cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
      if (i == 1 + 2*20 + 2) i_init_done = 1'b0;
    end
  endtask

  task automatic test_trigger();
    obs_t o, e;
    int n;
    do_reset();
    set_geom(4, 2, 3, 2, 2, 5);
    i_trigger_mode = 1'b1;
    i_init_done = 1'b1;
    push_idle(10);
    add_frame(4, 2, 3, 2, 2, 5);
    push_idle(20);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL trigger cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
      if (i == 8 || i == 26) i_trigger = 1'b1;
      else i_trigger = 1'b0;
    end
    n_assert++;
    if (ov_frame_cnt !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL trigger_frame_cnt: got %0d, expected 1", ov_frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t o, e;
    int n;
    do_reset();
    set_geom(4, 2, 3, 2, 2, 5);
    i_init_done = 1'b1;
    push_idle(1);
    add_frame(4, 2, 3, 2, 2, 5);
    add_frame(4, 2, 3, 2, 2, 5);
    // Stop on the third lval clock of line 1 in the second frame.
    n = 1 + 20 + 11 + 1;
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL pre_reset cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
    reset = 1'b1;
    exp_q.delete();
    model_fcnt = 0;
    push_idle(2);
    add_frame(4, 2, 3, 2, 2, 5);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL post_reset cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
      reset = 1'b0;
    end
  endtask

  task automatic test_geometry_change();
    obs_t o, e;
    int n;
    do_reset();
    set_geom(4, 2, 3, 2, 2, 5);
    i_init_done = 1'b1;
    push_idle(1);
    add_frame(4, 2, 3, 2, 2, 5);
    add_frame(6, 2, 3, 2, 2, 5);
    push_idle(10);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL geometry_change cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
      if (i == 5) iv_line_clks = CW'(6);
      if (i == 1 + 20 + 2) i_init_done = 1'b0;
    end
  endtask

  task automatic test_zero_blanks();
    obs_t o, e;
    int n, len0;
    do_reset();
    set_geom(4, 2, 0, 0, 0, 0);
    i_init_done = 1'b1;
    push_idle(1);
    add_frame(4, 2, 0, 0, 0, 0);
    len0 = exp_q.size() - 1;
    add_frame(4, 2, 0, 0, 0, 0);
    push_idle(8);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL zero_blanks cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
      if (i == 1 + len0) i_init_done = 1'b0;
    end
  endtask

  task automatic test_zero_lines();
    obs_t o, e;
    int n;
    do_reset();
    set_geom(4, 0, 3, 2, 2, 5);
    i_init_done = 1'b1;
    push_idle(60);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      o = sample();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL zero_lines cycle %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
      if (i == 30) begin
        iv_line_num  = CW'(2);
        iv_line_clks = CW'(0);
      end
    end
    i_init_done = 1'b0;
  endtask

  task automatic test_random();
    obs_t o, e;
    int n, len0, lc, ln, hb, fr, bk, vb;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      lc = $urandom_range(5, 1); ln = $urandom_range(3, 1);
      hb = $urandom_range(3, 0); fr = $urandom_range(3, 0);
      bk = $urandom_range(3, 0); vb = $urandom_range(3, 0);
      set_geom(lc, ln, hb, fr, bk, vb);
      i_init_done = 1'b1;
      push_idle(1);
      add_frame(lc, ln, hb, fr, bk, vb);
      len0 = exp_q.size() - 1;
      add_frame(lc, ln, hb, fr, bk, vb);
      push_idle(8);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        tick();
        e = exp_q.pop_front();
        o = sample();
        n_assert++;
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL random it%0d geom=%0d/%0d/%0d/%0d/%0d/%0d cycle %0d: got %s, expected %s",
                   it, lc, ln, hb, fr, bk, vb, i, fmt(o), fmt(e));
        end
        if (i == 1 + len0) i_init_done = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; i_init_done = 1'b0; i_trigger_mode = 1'b0; i_trigger = 1'b0;
    set_geom(0, 0, 0, 0, 0, 0);
    test_reset();
    test_free_run();
    test_trigger();
    test_reset_mid_frame();
    test_geometry_change();
    test_zero_blanks();
    test_zero_lines();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
